alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_bit_slice.sv | 37 +++
 rtl/alu_serial_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU.
//   - 3-bit op encodings (OP_*)
//   - FSM state encoding (state_e)
//   - bit-slice function select (sel_e)
//   - small op-class helpers used by the controller
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SUM  = 2'd0,
    SEL_XOR  = 2'd1,
    SEL_NAND = 2'd2,
    SEL_NOR  = 2'd3
  } sel_e;

  // Ops that run the adder with b inverted and carry-in preset to 1.
  function automatic logic op_is_sub(input logic [2:0] o);
    return (o == OP_SUB) || (o == OP_SLT);
  endfunction

  // Ops whose carryout/overflow flags are meaningful.
  function automatic logic op_is_arith(input logic [2:0] o);
    return (o == OP_ADD) || op_is_sub(o);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice, purely combinational.
// Ports:
//   a, b         operand bits
//   cin          carry in
//   invta/invtb  invert a / b before use
//   sel          function select (sum, xor, nand, nor)
//   result       slice output bit
//   cout         full-adder carry out of the (optionally inverted) inputs
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic invta,
  input  logic invtb,
  input  sel_e sel,
  output logic result,
  output logic cout
);

  logic ai, bi;

  assign ai   = a ^ invta;
  assign bi   = b ^ invtb;
  assign cout = (ai & bi) | (cin & (ai ^ bi));

  always_comb begin
    case (sel)
      SEL_SUM:  result = ai ^ bi ^ cin;
      SEL_XOR:  result = ai ^ bi;
      SEL_NAND: result = ~(ai & bi);
      default:  result = ~(ai | bi);
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: accepts an op in IDLE, streams one operand bit
// per RUN cycle (LSB first) through a single alu_bit_slice, and publishes the
// result plus flags on entry to FINISH, where done pulses for one cycle.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, op, a, b              request; sampled/captured only in IDLE
//   busy                         high in RUN and FINISH
//   done                         one-cycle pulse in FINISH
//   result, carryout, overflow,
//   zero                         final result/flags, held until next result
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d, ovf_q, ovf_d, zero_q, zero_d;

  logic             invta, invtb, s_res, s_cout, last_ovf;
  sel_e             sel;
  logic [WIDTH-1:0] full;

  // Slice controls. AND/OR reuse NOR/NAND through De Morgan on inverted inputs.
  always_comb begin
    invta = 1'b0;
    invtb = 1'b0;
    sel   = SEL_SUM;
    case (op_q)
      OP_SUB, OP_SLT: invtb = 1'b1;
      OP_XOR:         sel = SEL_XOR;
      OP_NAND:        sel = SEL_NAND;
      OP_NOR:         sel = SEL_NOR;
      OP_AND: begin invta = 1'b1; invtb = 1'b1; sel = SEL_NOR;  end
      OP_OR:  begin invta = 1'b1; invtb = 1'b1; sel = SEL_NAND; end
      default: ;
    endcase
  end

  alu_bit_slice u_slice (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cin    (carry_q),
    .invta  (invta),
    .invtb  (invtb),
    .sel    (sel),
    .result (s_res),
    .cout   (s_cout)
  );

  // Final values are formed from the shift register plus the slice's
  // current output so they can be registered on the edge into FINISH.
  assign last_ovf = carry_q ^ s_cout;
  always_comb begin
    full = {s_res, sh_q[WIDTH-1:1]};
    if (op_q == OP_SLT) full = {{(WIDTH-1){1'b0}}, s_res ^ last_ovf};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = op_is_sub(op);
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = {s_res, sh_q[WIDTH-1:1]};
        carry_d = s_cout;
        if (idx_q == LAST) begin
          state_d  = S_FINISH;
          result_d = full;
          co_d     = op_is_arith(op_q) & s_cout;
          ovf_d    = op_is_arith(op_q) & last_ovf;
          zero_d   = (full == '0);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN) || (state_q == S_FINISH);
  assign done     = (state_q == S_FINISH);
  assign result   = result_q;
  assign carryout = co_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;  // cycles from the accept cycle to the done cycle

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, carryout, overflow, zero;
  logic [W-1:0] result;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] res;
    logic co, ov, z;
    string name;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;

  // Reference model: whole-word arithmetic, independent of the serial datapath.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, y, input string nm);
    exp_t e;
    logic [W:0] s;
    e.name = nm; e.co = 1'b0; e.ov = 1'b0; e.res = '0;
    case (o)
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0]; e.co = s[W];
        e.ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      OP_SUB, OP_SLT: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.co = s[W];
        e.ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        e.res = (o == OP_SUB) ? s[W-1:0] : {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      end
      OP_XOR:  e.res = x ^ y;
      OP_AND:  e.res = x & y;
      OP_NAND: e.res = ~(x & y);
      OP_NOR:  e.res = ~(x | y);
      default: e.res = x | y;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Present a request in an IDLE cycle; the expectation is queued as it is driven.
  task automatic drive_start(input logic [2:0] o, input logic [W-1:0] x, y, input string nm);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y, nm));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; n = cycles after the accept cycle.
  task automatic wait_done(output int n, output bit seen);
    seen = 1'b0; n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin n = i; seen = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, result, carryout, overflow, zero} !== '0) begin
      fails++;
      $display("FAIL reset_state busy=%b done=%b result=%h co=%b ov=%b z=%b, all must be 0",
               busy, done, result, carryout, overflow, zero);
    end
    reset_n = 1'b1;
  endtask

  task automatic run_table(input logic [2:0] ops[], input logic [W-1:0] xs[], input logic [W-1:0] ys[], input string tag);
    int n; bit seen; exp_t e;
    for (int k = 0; k < ops.size(); k++) begin
      drive_start(ops[k], xs[k], ys[k], $sformatf("%s%0d", tag, k));
      wait_done(n, seen);
      e = sb.pop_front();
      tests++;
      if (!seen) begin
        fails++; $display("FAIL %s_timeout done never seen", e.name); continue;
      end
      if (n != LAT || busy !== 1'b1) begin
        fails++; $display("FAIL %s_latency got %0d busy=%b, need %0d busy=1", e.name, n, busy, LAT);
      end
      tests++;
      if ({result, carryout, overflow, zero} !== {e.res, e.co, e.ov, e.z}) begin
        fails++;
        $display("FAIL %s result=%h co=%b ov=%b z=%b, expected result=%h co=%b ov=%b z=%b",
                 e.name, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL %s_pulse done=%b busy=%b after finish, need 0/0", e.name, done, busy);
      end
    end
  endtask

  task automatic test_arith();
    logic [2:0]   ops[] = '{OP_ADD, OP_SUB, OP_SLT, OP_ADD, OP_SUB, OP_SLT, OP_SLT, OP_ADD};
    logic [W-1:0] xs[]  = '{32'h7FFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3, 32'h0};
    logic [W-1:0] ys[]  = '{32'h1, 32'h5, 32'h1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'h9, $urandom};
    xs[7] = $urandom;
    run_table(ops, xs, ys, "arith");
  endtask

  task automatic test_logic();
    logic [2:0]   ops[] = '{OP_AND, OP_OR, OP_NAND, OP_XOR, OP_NOR, OP_AND, OP_XOR};
    logic [W-1:0] xs[]  = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1234_5678, 32'hA5A5_A5A5};
    logic [W-1:0] ys[]  = '{32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hEDCB_A987, 32'hA5A5_A5A5};
    run_table(ops, xs, ys, "logic");
  endtask

  task automatic test_busy_ignore();
    int ndone = 0; exp_t e, orig;
    drive_start(OP_ADD, 32'h1234_5678, 32'h1111_1111, "ignore_add");
    orig = sb[0];
    for (int n = 1; n <= 40; n++) begin
      start = (n == 5) || (n == 20);
      if (start) begin op = OP_NOR; a = 32'hDEAD_BEEF + n; b = 32'h0F0F_0000; end
      @(negedge clk);
      if (done) begin
        ndone++;
        if (sb.size() == 0) begin
          tests++; fails++; $display("FAIL ignore_extra_done scoreboard empty at cycle %0d", n);
        end else begin
          e = sb.pop_front();
          tests++;
          if (result !== e.res || n != LAT) begin
            fails++; $display("FAIL %s result=%h cyc=%0d, expected %h cyc=%0d", e.name, result, n, e.res, LAT);
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    tests++;
    if (ndone != 1 || result !== orig.res) begin
      fails++; $display("FAIL ignore_single_done pulses=%0d result=%h, need 1 and %h", ndone, result, orig.res);
    end
  endtask

  task automatic test_reset_abort();
    int n, ndone = 0; bit seen; exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = OP_ADD; a = 32'h0F0F_0F0F; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, result, carryout, overflow, zero} !== '0) begin
      fails++;
      $display("FAIL abort_async_clear busy=%b done=%b result=%h co=%b ov=%b z=%b, all must be 0",
               busy, done, result, carryout, overflow, zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    tests++;
    if (ndone != 0) begin fails++; $display("FAIL abort_no_done got %0d pulses, need 0", ndone); end
    drive_start(OP_ADD, 32'd2, 32'd3, "abort_add_2_3");
    wait_done(n, seen);
    e = sb.pop_front();
    tests++;
    if (!seen || n != LAT || result !== 32'd5 || result !== e.res) begin
      fails++; $display("FAIL %s seen=%b cyc=%0d result=%h, need cyc=%0d result=5", e.name, seen, n, result, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs[3] = '{32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] ys[3] = '{32'h2, 32'h1, 32'h8000_0000};
    int n, last = 0; bit seen; exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = OP_ADD; a = xs[0]; b = ys[0];
    sb.push_back(model(OP_ADD, xs[0], ys[0], "b2b0"));
    for (int k = 0; k < 3; k++) begin
      wait_done(n, seen);
      if (!seen) begin
        tests++; fails++; $display("FAIL b2b_timeout op %0d never completed", k);
        sb.delete(); break;
      end
      if (k > 0) begin
        tests++;
        if (cyc - last != W + 2) begin
          fails++; $display("FAIL b2b_period got %0d cycles, need %0d", cyc - last, W + 2);
        end
      end
      last = cyc;
      e = sb.pop_front();
      tests++;
      if ({result, carryout, overflow, zero} !== {e.res, e.co, e.ov, e.z}) begin
        fails++;
        $display("FAIL %s result=%h co=%b ov=%b z=%b, expected result=%h co=%b ov=%b z=%b",
                 e.name, result, carryout, overflow, zero, e.res, e.co, e.ov, e.z);
      end
      if (k < 2) begin
        a = xs[k+1]; b = ys[k+1];
        sb.push_back(model(OP_ADD, xs[k+1], ys[k+1], $sformatf("b2b%0d", k + 1)));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL b2b_pulse_width done=%b, need 0", done); end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
